// File: rtl/serial_frame_demux.sv
// Serial frame demultiplexer: decodes start/address/length/payload frames from
// a one-bit stream and routes each payload bit to the addressed channel line.
module serial_frame_demux #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned LEN_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   serin,
  input  logic                   abort,
  output logic [2**ADDR_W-1:0]   dout,
  output logic                   outvalid,
  output logic [ADDR_W-1:0]      ch,
  output logic                   done,
  output logic                   busy
);

  localparam int unsigned CH    = 2**ADDR_W;
  localparam int unsigned CNT_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    LEN  = 2'd2,
    DATA = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_rem;
  logic [CH-1:0]       r_dout;
  logic                r_outvalid;
  logic [ADDR_W-1:0]   r_ch;
  logic                r_done;
  logic                r_busy;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [LEN_W-1:0]    w_len_nxt;
  logic [LEN_W-1:0]    w_rem_nxt;
  logic [CH-1:0]       w_dout_nxt;
  logic                w_outvalid_nxt;
  logic [ADDR_W-1:0]   w_ch_nxt;
  logic                w_done_nxt;
  logic                w_busy_nxt;
  logic [ADDR_W-1:0]   w_addr_shift;
  logic [LEN_W-1:0]    w_len_shift;

  // Field registers with the incoming bit shifted in at the LSB (MSB-first fields)
  assign w_addr_shift = ADDR_W'({r_addr, serin});
  assign w_len_shift  = LEN_W'({r_len, serin});

  // Next-state and next-output decode; abort in any non-idle state overrides
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_addr_nxt     = r_addr;
    w_len_nxt      = r_len;
    w_rem_nxt      = r_rem;
    w_ch_nxt       = r_ch;
    w_dout_nxt     = '0;
    w_outvalid_nxt = 1'b0;
    w_done_nxt     = 1'b0;

    case (r_state)
      IDLE: begin
        if (serin) begin
          w_state_nxt = ADDR;
          w_cnt_nxt   = '0;
        end
      end
      ADDR: begin
        w_addr_nxt = w_addr_shift;
        w_cnt_nxt  = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(ADDR_W - 1)) begin
          w_state_nxt = LEN;
          w_cnt_nxt   = '0;
          w_ch_nxt    = w_addr_shift;
        end
      end
      LEN: begin
        w_len_nxt = w_len_shift;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(LEN_W - 1)) begin
          w_cnt_nxt = '0;
          if (w_len_shift == '0) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_rem_nxt   = w_len_shift;
            w_state_nxt = DATA;
          end
        end
      end
      DATA: begin
        w_dout_nxt     = CH'(serin) << r_addr;
        w_outvalid_nxt = 1'b1;
        w_rem_nxt      = r_rem - LEN_W'(1);
        if (r_rem == LEN_W'(1)) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (abort && (r_state != IDLE)) begin
      w_state_nxt    = IDLE;
      w_cnt_nxt      = '0;
      w_rem_nxt      = '0;
      w_ch_nxt       = r_ch;
      w_dout_nxt     = '0;
      w_outvalid_nxt = 1'b0;
      w_done_nxt     = 1'b0;
    end

    // Busy covers the frame plus the first idle cycle after it ends
    w_busy_nxt = (r_state != IDLE) || (w_state_nxt != IDLE);
  end

  // State, field and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_rem      <= '0;
      r_dout     <= '0;
      r_outvalid <= 1'b0;
      r_ch       <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_addr     <= w_addr_nxt;
      r_len      <= w_len_nxt;
      r_rem      <= w_rem_nxt;
      r_dout     <= w_dout_nxt;
      r_outvalid <= w_outvalid_nxt;
      r_ch       <= w_ch_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign dout     = r_dout;
  assign outvalid = r_outvalid;
  assign ch       = r_ch;
  assign done     = r_done;
  assign busy     = r_busy;

endmodule

// File: tb/tb_serial_frame_demux.sv
// Table-driven bench for serial_frame_demux (ADDR_W=2, LEN_W=3).
module tb_serial_frame_demux;

  logic       clk;
  logic       rst;
  logic       serin;
  logic       abort;
  logic [3:0] dout;
  logic       outvalid;
  logic [1:0] ch;
  logic       done;
  logic       busy;

  int checks;
  int failures;

  typedef struct {
    logic       r;
    logic       s;
    logic       a;
    logic [3:0] dout;
    logic       ov;
    logic [1:0] ch;
    logic       dn;
    logic       bs;
  } vec_t;

  vec_t tbl[$];

  serial_frame_demux #(.ADDR_W(2), .LEN_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .serin    (serin),
    .abort    (abort),
    .dout     (dout),
    .outvalid (outvalid),
    .ch       (ch),
    .done     (done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic s, logic a, logic [3:0] d,
                              logic ov, logic [1:0] c, logic dn, logic bs);
    vec_t v;
    v.r = r; v.s = s; v.a = a; v.dout = d; v.ov = ov; v.ch = c; v.dn = dn; v.bs = bs;
    return v;
  endfunction

  function automatic void add(logic r, logic s, logic a, logic [3:0] d,
                              logic ov, logic [1:0] c, logic dn, logic bs);
    tbl.push_back(mk(r, s, a, d, ov, c, dn, bs));
  endfunction

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, let one rising edge pass, compare.
  task automatic run(input vec_t v, input int idx);
    rst   = v.r;
    serin = v.s;
    abort = v.a;
    @(posedge clk);
    @(negedge clk);
    chk("dout",     idx, dout,           v.dout);
    chk("outvalid", idx, 4'(outvalid),   4'(v.ov));
    chk("ch",       idx, 4'(ch),         4'(v.ch));
    chk("done",     idx, 4'(done),       4'(v.dn));
    chk("busy",     idx, 4'(busy),       4'(v.bs));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b0;
    serin = 1'b0;
    abort = 1'b0;
    @(negedge clk);

    // Reset and idle
    add(0,0,0, 4'h0,0,2'd0,0,0);
    add(0,1,1, 4'h0,0,2'd0,0,0);
    add(1,0,0, 4'h0,0,2'd0,0,0);
    // Basic frame: ch=2, L=3, payload 1,0,1
    add(1,1,0, 4'h0,0,2'd0,0,1);
    add(1,1,0, 4'h0,0,2'd0,0,1);
    add(1,0,0, 4'h0,0,2'd2,0,1);
    add(1,0,0, 4'h0,0,2'd2,0,1);
    add(1,1,0, 4'h0,0,2'd2,0,1);
    add(1,1,0, 4'h0,0,2'd2,0,1);
    add(1,1,0, 4'h4,1,2'd2,0,1);
    add(1,0,0, 4'h0,1,2'd2,0,1);
    add(1,1,0, 4'h4,1,2'd2,1,1);
    add(1,0,0, 4'h0,0,2'd2,0,0);
    // Zero length on ch=1
    add(1,1,0, 4'h0,0,2'd2,0,1);
    add(1,0,0, 4'h0,0,2'd2,0,1);
    add(1,1,0, 4'h0,0,2'd1,0,1);
    add(1,0,0, 4'h0,0,2'd1,0,1);
    add(1,0,0, 4'h0,0,2'd1,0,1);
    add(1,0,0, 4'h0,0,2'd1,1,1);
    add(1,0,0, 4'h0,0,2'd1,0,0);
    // Back-to-back: ch=3 L=1 payload 1, then ch=0 L=2 payload 0,1
    add(1,1,0, 4'h0,0,2'd1,0,1);
    add(1,1,0, 4'h0,0,2'd1,0,1);
    add(1,1,0, 4'h0,0,2'd3,0,1);
    add(1,0,0, 4'h0,0,2'd3,0,1);
    add(1,0,0, 4'h0,0,2'd3,0,1);
    add(1,1,0, 4'h0,0,2'd3,0,1);
    add(1,1,0, 4'h8,1,2'd3,1,1);
    add(1,1,0, 4'h0,0,2'd3,0,1);
    add(1,0,0, 4'h0,0,2'd3,0,1);
    add(1,0,0, 4'h0,0,2'd0,0,1);
    add(1,0,0, 4'h0,0,2'd0,0,1);
    add(1,1,0, 4'h0,0,2'd0,0,1);
    add(1,0,0, 4'h0,0,2'd0,0,1);
    add(1,0,0, 4'h0,1,2'd0,0,1);
    add(1,1,0, 4'h1,1,2'd0,1,1);
    add(1,0,0, 4'h0,0,2'd0,0,0);
    // Max length: ch=0, L=7, payload 1,0,1,0,1,0,1
    add(1,1,0, 4'h0,0,2'd0,0,1);
    add(1,0,0, 4'h0,0,2'd0,0,1);
    add(1,0,0, 4'h0,0,2'd0,0,1);
    add(1,1,0, 4'h0,0,2'd0,0,1);
    add(1,1,0, 4'h0,0,2'd0,0,1);
    add(1,1,0, 4'h0,0,2'd0,0,1);
    for (int i = 0; i < 7; i++) begin
      logic b;
      b = ((i % 2) == 0);
      add(1,b,0, {3'b000,b},1,2'd0,(i == 6),1);
    end
    add(1,0,0, 4'h0,0,2'd0,0,0);
    // Abort on the 2nd payload bit of ch=1, L=5
    add(1,1,0, 4'h0,0,2'd0,0,1);
    add(1,0,0, 4'h0,0,2'd0,0,1);
    add(1,1,0, 4'h0,0,2'd1,0,1);
    add(1,1,0, 4'h0,0,2'd1,0,1);
    add(1,0,0, 4'h0,0,2'd1,0,1);
    add(1,1,0, 4'h0,0,2'd1,0,1);
    add(1,1,0, 4'h2,1,2'd1,0,1);
    add(1,1,1, 4'h0,0,2'd1,0,1);
    add(1,0,0, 4'h0,0,2'd1,0,0);
    // Abort ignored in IDLE; following frame ch=2, L=1, payload 1
    add(1,1,1, 4'h0,0,2'd1,0,1);
    add(1,1,0, 4'h0,0,2'd1,0,1);
    add(1,0,0, 4'h0,0,2'd2,0,1);
    add(1,0,0, 4'h0,0,2'd2,0,1);
    add(1,0,0, 4'h0,0,2'd2,0,1);
    add(1,1,0, 4'h0,0,2'd2,0,1);
    add(1,1,0, 4'h4,1,2'd2,1,1);
    add(1,0,0, 4'h0,0,2'd2,0,0);
    // Abort during ADDR
    add(1,1,0, 4'h0,0,2'd2,0,1);
    add(1,0,1, 4'h0,0,2'd2,0,1);
    add(1,0,0, 4'h0,0,2'd2,0,0);

    for (int i = 0; i < tbl.size(); i++) run(tbl[i], i);

    // Reset at the 3rd payload edge of ch=3, L=5 (abort asserted too; reset wins)
    run(mk(1,1,0, 4'h0,0,2'd2,0,1), 100);
    run(mk(1,1,0, 4'h0,0,2'd2,0,1), 101);
    run(mk(1,1,0, 4'h0,0,2'd3,0,1), 102);
    run(mk(1,1,0, 4'h0,0,2'd3,0,1), 103);
    run(mk(1,0,0, 4'h0,0,2'd3,0,1), 104);
    run(mk(1,1,0, 4'h0,0,2'd3,0,1), 105);
    run(mk(1,1,0, 4'h8,1,2'd3,0,1), 106);
    run(mk(1,0,0, 4'h0,1,2'd3,0,1), 107);
    run(mk(0,1,1, 4'h0,0,2'd0,0,0), 108);
    for (int i = 0; i < 3; i++) run(mk(1,0,0, 4'h0,0,2'd0,0,0), 109 + i);

    // Reset pulse between edges must not disturb a frame in progress
    run(mk(1,1,0, 4'h0,0,2'd0,0,1), 120);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    run(mk(1,1,0, 4'h0,0,2'd0,0,1), 121);
    run(mk(1,0,0, 4'h0,0,2'd2,0,1), 122);
    run(mk(1,0,1, 4'h0,0,2'd2,0,1), 123);
    run(mk(1,0,0, 4'h0,0,2'd2,0,0), 124);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
